// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults and pattern mode encodings
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CLK_DIV_DEF  = 2;
  localparam int COLOR_W_DEF  = 3;
  typedef enum logic [1:0] {MODE_VBAR, MODE_HBAR, MODE_CHECK, MODE_SOLID} mode_e;
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel-enable divider, h/v position counters and sync/active decode
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int SYNC_POL = 0,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic          clk_master,
  input  logic          reset,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          active_o,
  output logic          first_o,
  output logic          wrap_o
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic pe, h_end, v_end;
  always_comb begin
    pe    = div_q == DW'(CLK_DIV - 1);
    h_end = h_q == HW'(HT - 1);
    v_end = v_q == VW'(VT - 1);
    div_d = pe ? '0 : div_q + 1'b1;
    h_d   = pe ? (h_end ? '0 : h_q + 1'b1) : h_q;
    v_d   = pe && h_end ? (v_end ? '0 : v_q + 1'b1) : v_q;
  end
  always_ff @(posedge clk_master) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end
  assign h_o      = h_q;
  assign v_o      = v_q;
  assign hsync_o  = (32'(h_q) >= H_ACTIVE + H_FP && 32'(h_q) < H_ACTIVE + H_FP + H_SYNC) == (SYNC_POL != 0);
  assign vsync_o  = (32'(v_q) >= V_ACTIVE + V_FP && 32'(v_q) < V_ACTIVE + V_FP + V_SYNC) == (SYNC_POL != 0);
  assign active_o = 32'(h_q) < H_ACTIVE && 32'(v_q) < V_ACTIVE;
  // first clk_master cycle of pixel (0,0); wrap marks the pe that reloads (0,0)
  assign first_o  = div_q == '0 && h_q == '0 && v_q == '0;
  assign wrap_o   = pe && h_end && v_end;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing generator with frame-locked test pattern selection
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int SYNC_POL = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic               clk_master,
  input  logic               reset,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] display,
  output logic               active,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y,
  output logic               frame_start
);
  localparam int HBW = H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1;
  localparam int VBW = V_ACTIVE >= 8 ? V_ACTIVE / 8 : 1;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic hs, vs, act, first, wrap;
  logic [31:0] hx, vx;
  logic [COLOR_W-1:0] pat;
  mode_e mode_q;
  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .SYNC_POL(SYNC_POL)
  ) u_sync (
    .clk_master(clk_master), .reset(reset), .h_o(h), .v_o(v),
    .hsync_o(hs), .vsync_o(vs), .active_o(act), .first_o(first), .wrap_o(wrap)
  );
  always_comb begin
    hx  = 32'(h);
    vx  = 32'(v);
    pat = mode_q == MODE_VBAR  ? COLOR_W'(3'(7 - hx / HBW)) :
          mode_q == MODE_HBAR  ? COLOR_W'(3'(7 - vx / VBW)) :
          mode_q == MODE_CHECK ? {COLOR_W{hx[5] ^ vx[5]}} : '1;
  end
  // mode_q changes on the same edge the counters reload (0,0), so a frame never mixes patterns
  always_ff @(posedge clk_master) begin
    if (reset) begin
      hsync       <= SYNC_POL == 0;
      vsync       <= SYNC_POL == 0;
      display     <= '0;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_VBAR;
    end else begin
      hsync       <= hs;
      vsync       <= vs;
      display     <= act ? pat : '0;
      active      <= act;
      x           <= h;
      y           <= v;
      frame_start <= first;
      if (wrap) mode_q <= mode_e'(mode);
    end
  end
endmodule
